mm2x2_sched: RTL and testbench

Round-robin scheduler that shares one sequential 2x2 matrix-multiply engine between two requesters. Each requester presents packed 8-bit 2x2 operands A and B with a valid/ready handshake. The block grants one request at a time and sequences the shared 8x8 multiply-accumulate over eight cycles. It returns the packed 2x2 result, tagged with the requester ID, through a valid/ready response port. It sits between the NN layer controllers and the matrix datapath.

---
 rtl/mm2x2_pkg.sv | 21 ++
 rtl/mm2x2_mac_engine.sv | 73 +++++++
 rtl/mm2x2_sched.sv | 103 ++++++++++
 tb/tb_mm2x2_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm2x2_pkg.sv
// Shared definitions for the 2x2 matrix-multiply scheduler: element width, FSM states,
// step width and packed-element bit offsets.
package mm2x2_pkg;

  localparam int unsigned ElemWDefault = 8;
  localparam int unsigned StepW        = 3;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone
  } state_e;

  // Packed layout is {e00, e01, e10, e11}, MSB first.
  function automatic int unsigned elem_lsb(input logic i, input logic j, input int unsigned w);
    int unsigned idx;
    idx = {30'b0, i, j};
    return (3 - idx) * w;
  endfunction

endpackage

// File: rtl/mm2x2_mac_engine.sv
// Sequential 2x2 multiply engine: one ELEM_W x ELEM_W product per enabled step.
// MM2X2_SCHED_SAT_EN selects saturating accumulator write-back; otherwise it wraps.
module mm2x2_mac_engine
  import mm2x2_pkg::*;
#(
  parameter int unsigned ELEM_W = ElemWDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  en_i,
  input  logic [StepW-1:0]      step_i,
  input  logic [4*ELEM_W-1:0]   a_i,
  input  logic [4*ELEM_W-1:0]   b_i,
  output logic [4*ELEM_W-1:0]   res_o
);

  localparam int unsigned PW = 2 * ELEM_W;

  logic [4*ELEM_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [ELEM_W-1:0]   a_el, b_el, acc_el, wb;
  logic [PW-1:0]       prod;
  logic [PW:0]         sum;
  logic                ii, jj, kk;

`ifdef MM2X2_SCHED_SAT_EN
  localparam logic [PW:0] MaxEl = {{(PW + 1 - ELEM_W){1'b0}}, {ELEM_W{1'b1}}};
`endif

  // step = {i, j, k}: element (i,j) accumulates a[i][k] * b[k][j]
  assign ii = step_i[2];
  assign jj = step_i[1];
  assign kk = step_i[0];

  always_comb begin
    a_el   = a_q[elem_lsb(ii, kk, ELEM_W) +: ELEM_W];
    b_el   = b_q[elem_lsb(kk, jj, ELEM_W) +: ELEM_W];
    acc_el = acc_q[elem_lsb(ii, jj, ELEM_W) +: ELEM_W];
    prod   = a_el * b_el;
    sum    = {{(PW + 1 - ELEM_W){1'b0}}, acc_el} + {1'b0, prod};
`ifdef MM2X2_SCHED_SAT_EN
    wb     = (sum > MaxEl) ? {ELEM_W{1'b1}} : ELEM_W'(sum);
`else
    wb     = ELEM_W'(sum);
`endif

    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
    end else if (en_i) begin
      acc_d[elem_lsb(ii, jj, ELEM_W) +: ELEM_W] = wb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign res_o = acc_q;

endmodule

// File: rtl/mm2x2_sched.sv
// Round-robin scheduler sharing one sequential 2x2 matrix-multiply engine between two
// requesters. MM2X2_SCHED_SAT_EN (in the engine) selects saturating accumulation.
module mm2x2_sched
  import mm2x2_pkg::*;
#(
  parameter int unsigned ELEM_W = ElemWDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [4*ELEM_W-1:0] req0_a,
  input  logic [4*ELEM_W-1:0] req0_b,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [4*ELEM_W-1:0] req1_a,
  input  logic [4*ELEM_W-1:0] req1_b,
  output logic                req1_ready,
  output logic                rsp_valid,
  output logic [4*ELEM_W-1:0] rsp_res,
  output logic                rsp_id,
  input  logic                rsp_ready
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             rsp_id_q, rsp_id_d;
  logic [StepW-1:0] step_q, step_d;
  logic             grant0, grant1, load, en;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rsp_id_d  = rsp_id_q;
    step_d    = step_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    load      = 1'b0;
    en        = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie the requester that was not served last wins
        if (!reset) begin
          grant0 = req0_valid && (!req1_valid || last_q);
          grant1 = req1_valid && (!req0_valid || !last_q);
        end
        if (grant0 || grant1) begin
          load     = 1'b1;
          last_d   = grant1;
          rsp_id_d = grant1;
          step_d   = '0;
          state_d  = StMac;
        end
      end
      StMac: begin
        en     = 1'b1;
        step_d = step_q + 1'b1;
        if (step_q == '1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      rsp_id_q <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rsp_id_q <= rsp_id_d;
      step_q   <= step_d;
    end
  end

  mm2x2_mac_engine #(
    .ELEM_W (ELEM_W)
  ) u_engine (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .en_i   (en),
    .step_i (step_q),
    .a_i    (grant1 ? req1_a : req0_a),
    .b_i    (grant1 ? req1_b : req0_b),
    .res_o  (rsp_res)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_mm2x2_sched.sv
// Scoreboard bench for mm2x2_sched: requests push model results, a monitor pops on responses.
module tb_mm2x2_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_ready = 1'b1;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, hs_cyc = 0, ready_mode = 0;
  logic        tb_last = 1'b1;
  logic        eg0, eg1;
  logic        prev_hold = 1'b0, prev_v = 1'b0, prev_id = 1'b0;
  logic [31:0] prev_res = '0;

  mm2x2_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_res    (rsp_res),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full matrix product, then saturate or wrap each element
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    int          am[2][2];
    int          bm[2][2];
    int          s;
    logic [31:0] r;
    for (int n = 0; n < 4; n++) begin
      am[n / 2][n % 2] = int'(a[31 - 8 * n -: 8]);
      bm[n / 2][n % 2] = int'(b[31 - 8 * n -: 8]);
    end
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
`ifdef MM2X2_SCHED_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        r[31 - 8 * (2 * i + j) -: 8] = 8'(s);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Request side: arbitration check and scoreboard push
  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in_reset", {30'b0, req1_ready, req0_ready}, 32'd0);
      tb_last = 1'b1;
    end else begin
      if (sb.size() == 0) begin
        eg0 = req0_valid && (!req1_valid || tb_last);
        eg1 = req1_valid && (!req0_valid || !tb_last);
        chk("grant", {30'b0, req1_ready, req0_ready}, {30'b0, eg1, eg0});
      end else begin
        chk("ready_busy", {30'b0, req1_ready, req0_ready}, 32'd0);
      end
      if (req0_valid && req0_ready) begin
        sb.push_back('{id: 1'b0, res: model(req0_a, req0_b)});
        tb_last = 1'b0;
        hs_cyc  = cyc;
      end else if (req1_valid && req1_ready) begin
        sb.push_back('{id: 1'b1, res: model(req1_a, req1_b)});
        tb_last = 1'b1;
        hs_cyc  = cyc;
      end
    end
  end

  // Response side: hold/latency checks and scoreboard pop
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_hold = 1'b0;
      prev_v    = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("hold_res", rsp_res, prev_res);
        chk("hold_id", {31'b0, rsp_id}, {31'b0, prev_id});
      end
      if (rsp_valid && !prev_v) chk("latency", cyc - hs_cyc, 32'd9);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got response res=%h id=%0d expected none", rsp_res, rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_res  = rsp_res;
      prev_id   = rsp_id;
      prev_v    = rsp_valid;
    end
  end

  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bit done = 1'b0;
    @(posedge clk);
    #1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: requester %0d got no ready, expected one within 300", id);
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got rsp_valid=0, expected 1 within 300 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || rsp_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
    end
  endtask

  logic [31:0] held_res;
  logic        held_id;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_res", rsp_res, 32'd0);
    chk("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Simultaneous from reset: req0 first, then req1 with identity A
    fork
      send(1'b0, $urandom, $urandom);
      send(1'b1, 32'h01000001, 32'h0A0B0C0D);
    join
    wait_rsp();
    chk("identity_res", rsp_res, 32'h0A0B0C0D);
    chk("identity_id", {31'b0, rsp_id}, 32'd1);
    wait_drain();
    fork
      send(1'b0, $urandom, $urandom);
      send(1'b1, $urandom, $urandom);
    join
    wait_drain();

    send(1'b0, 32'h01020304, 32'h05060708);
    wait_rsp();
    chk("single_res", rsp_res, 32'h13162B32);
    chk("single_id", {31'b0, rsp_id}, 32'd0);
    wait_drain();

    send(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rsp();
`ifdef MM2X2_SCHED_SAT_EN
    chk("overflow_res", rsp_res, 32'hFFFFFFFF);
`else
    chk("overflow_res", rsp_res, 32'h02020202);
`endif
    wait_drain();

    // Backpressure in DONE
    ready_mode = 1;
    send(1'b1, $urandom, $urandom);
    wait_rsp();
    held_res = rsp_res;
    held_id  = rsp_id;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_res", rsp_res, held_res);
      chk("bp_id", {31'b0, rsp_id}, {31'b0, held_id});
    end
    ready_mode = 0;
    @(negedge clk);
    chk("bp_accept", {30'b0, rsp_valid, rsp_ready}, 32'd3);
    @(negedge clk);
    chk("bp_released", {31'b0, rsp_valid}, 32'd0);
    chk("stale_res", rsp_res, held_res);

    // Reset at MAC step 4 drops the operation
    send(1'b0, $urandom, $urandom);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midreset_res", rsp_res, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    send(1'b1, $urandom, $urandom);
    wait_drain();
    fork
      send(1'b0, $urandom, $urandom);
      send(1'b1, $urandom, $urandom);
    join
    wait_drain();

    // Random traffic with random backpressure
    ready_mode = 2;
    fork
      for (int r = 0; r < 20; r++) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        send(1'b0, $urandom, $urandom);
      end
      for (int r = 0; r < 20; r++) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        send(1'b1, $urandom, $urandom);
      end
    join
    ready_mode = 0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
